// File: rtl/erasable_ram_pkg.sv
// -----------------------------------------------------------------------------
// erasable_ram_pkg
// Shared types and constants for the erasable-memory SRAM sequencer:
//   - state_t     : sequencer states
//   - ADDR_W      : SRAM word address width (2048 words)
//   - DATA_W      : SRAM word width
//   - CNT_W       : width of the per-state down-counter
//   - DEF_T_*     : default strobe timing, in clock cycles
//   - RDATA_RST   : reset value of the read-data register
// -----------------------------------------------------------------------------
package erasable_ram_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    localparam int DEF_T_SETUP  = 1;
    localparam int DEF_T_ACCESS = 4;
    localparam int DEF_T_WP     = 4;
    localparam int DEF_T_REC    = 1;

    localparam logic [DATA_W-1:0] RDATA_RST = 16'o0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_READ    = 3'd2,
        ST_WPULSE  = 3'd3,
        ST_WHOLD   = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

endpackage

// File: rtl/ram_dq_pad.sv
// -----------------------------------------------------------------------------
// ram_dq_pad
// Tristate merge for the SRAM data bus, used by the board-level wrapper to join
// the controller's split data path to the SRAM DQL/DQU pins.
// Ports:
//   ram_dq_out [15:0] in    : word to drive onto the bus
//   ram_dq_oe         in    : 1 = drive DQ, 0 = release DQ (high-Z)
//   ram_dq_in  [15:0] out   : sensed bus value, returned to the controller
//   DQ         [15:0] inout : SRAM data pins
// -----------------------------------------------------------------------------
module ram_dq_pad (
    input  logic [15:0] ram_dq_out,
    input  logic        ram_dq_oe,
    output logic [15:0] ram_dq_in,
    inout  wire  [15:0] DQ
);

    assign DQ        = ram_dq_oe ? ram_dq_out : 16'hzzzz;
    assign ram_dq_in = DQ;

endmodule

// File: rtl/erasable_ram_ctrl.sv
// -----------------------------------------------------------------------------
// erasable_ram_ctrl
// Sequencer between the erasable-memory request side and a 2048 x 16
// asynchronous SRAM. One word read or write per req/req_ack handshake; all
// SRAM strobes, address, data and drive enable come straight from flops.
// Ports:
//   SIM_CLK, SIM_RST          : clock, asynchronous active-low reset
//   req, req_we               : request (held until req_ack), 1 = write
//   req_addr[10:0]            : word address
//   req_wdata[15:0]           : write word
//   req_ack                   : request accepted this cycle (combinational)
//   rsp_valid                 : one-cycle completion pulse (reads and writes)
//   rsp_rdata[15:0]           : last read word, held until the next read ends
//   busy                      : sequencer not idle
//   ram_E_/G_/W_/UB_/LB_      : active-low SRAM strobes
//   ram_A[15:0]               : SRAM address, upper five bits tied low
//   ram_dq_out[15:0], ram_dq_oe : write data and bus drive enable
//   ram_dq_in[15:0]           : sensed SRAM data
// -----------------------------------------------------------------------------
module erasable_ram_ctrl
    import erasable_ram_pkg::*;
#(
    parameter int T_SETUP  = DEF_T_SETUP,
    parameter int T_ACCESS = DEF_T_ACCESS,
    parameter int T_WP     = DEF_T_WP,
    parameter int T_REC    = DEF_T_REC
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ack,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              ram_E_,
    output logic              ram_G_,
    output logic              ram_W_,
    output logic              ram_UB_,
    output logic              ram_LB_,
    output logic [15:0]       ram_A,
    output logic [DATA_W-1:0] ram_dq_out,
    output logic              ram_dq_oe,
    input  logic [DATA_W-1:0] ram_dq_in
);

    if (T_SETUP < 1 || T_ACCESS < 1 || T_WP < 1 || T_REC < 1) begin : g_param_check
        $error("erasable_ram_ctrl: every timing parameter must be at least 1");
    end

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_next_cnt;
    logic              w_ack;
    logic              w_next_we;
    logic              w_next_sel;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rsp_valid;
    logic              r_E_;
    logic              r_G_;
    logic              r_W_;
    logic              r_oe;

    assign w_ack     = req && (r_state == ST_IDLE);
    assign w_next_we = w_ack ? req_we : r_we;

    // Chip select is low in every state that touches the SRAM.
    assign w_next_sel = (w_next_state == ST_SETUP)  || (w_next_state == ST_READ) ||
                        (w_next_state == ST_WPULSE) || (w_next_state == ST_WHOLD);

    // NOTE: every signal driven here gets a default first so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_next_state = ST_SETUP;
                    w_next_cnt   = CNT_W'(T_SETUP - 1);
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    if (r_we) begin
                        w_next_state = ST_WPULSE;
                        w_next_cnt   = CNT_W'(T_WP - 1);
                    end else begin
                        w_next_state = ST_READ;
                        w_next_cnt   = CNT_W'(T_ACCESS - 1);
                    end
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            ST_READ: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_RECOVER;
                    w_next_cnt   = CNT_W'(T_REC - 1);
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            ST_WPULSE: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_WHOLD;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            ST_WHOLD: begin
                w_next_state = ST_RECOVER;
                w_next_cnt   = CNT_W'(T_REC - 1);
            end
            ST_RECOVER: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Operands change only on the ack edge, when E_ is (and was) high, so
    // address and data are stable for the whole chip-select window.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_ack) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Strobes are registered from the next state, so each pin toggles on the
    // edge that enters its state and cannot glitch. G_ and W_ are decoded
    // from disjoint states and can never be low together; oe is only set in
    // write states, so it is never high while G_ is low.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_E_        <= 1'b1;
            r_G_        <= 1'b1;
            r_W_        <= 1'b1;
            r_oe        <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_E_        <= !w_next_sel;
            r_G_        <= (w_next_state != ST_READ);
            r_W_        <= (w_next_state != ST_WPULSE);
            r_oe        <= ((w_next_state == ST_SETUP) && w_next_we) ||
                           (w_next_state == ST_WPULSE) || (w_next_state == ST_WHOLD);
            r_rsp_valid <= (w_next_state == ST_RECOVER) && (r_state != ST_RECOVER);
        end
    end

    // Read data is sampled on the edge that closes the last G_-low cycle.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_rdata <= RDATA_RST;
        end else if ((r_state == ST_READ) && (r_cnt == '0)) begin
            r_rdata <= ram_dq_in;
        end
    end

    assign req_ack    = w_ack;
    assign busy       = (r_state != ST_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rdata;
    assign ram_E_     = r_E_;
    assign ram_UB_    = r_E_;
    assign ram_LB_    = r_E_;
    assign ram_G_     = r_G_;
    assign ram_W_     = r_W_;
    assign ram_A      = {5'd0, r_addr};
    assign ram_dq_out = r_wdata;
    assign ram_dq_oe  = r_oe;

endmodule

// File: tb/tb_erasable_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_erasable_ram_ctrl
// Self-checking bench: the default-timing controller drives a behavioural SRAM
// through ram_dq_pad; a second instance with stretched timing checks latency.
// -----------------------------------------------------------------------------
module tb_erasable_ram_ctrl;

    localparam int TS = 1, TA = 4, TWP = 4, TR = 1;
    localparam logic [15:0] SRAM_INIT = 16'o40000;

    typedef struct {
        int          cyc;
        logic        we;
        logic [15:0] data;
    } exp_t;

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST = 1'b0;
    logic        req = 1'b0, req_we = 1'b0;
    logic [10:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ack, rsp_valid, busy;
    logic [15:0] rsp_rdata;
    logic        ram_E_, ram_G_, ram_W_, ram_UB_, ram_LB_, ram_dq_oe;
    logic [15:0] ram_A, ram_dq_out, ram_dq_in;
    wire  [15:0] dq_bus;

    logic        req2 = 1'b0, req2_we = 1'b0;
    logic [10:0] req2_addr = '0;
    logic [15:0] req2_wdata = '0;
    logic        ack2, rv2, busy2, e2_, g2_, w2_, ub2_, lb2_, oe2;
    logic [15:0] rdata2, a2, dqo2, dqi2;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [15:0] mem   [0:2047];
    logic [15:0] mem2  [0:2047];
    logic [15:0] model [0:2047];
    exp_t        exp_q [$];
    int          ovl_cnt = 0, oe_g_cnt = 0, oe_rise_cnt = 0, stab_cnt = 0;
    int          cont_cnt = 0, ub_cnt = 0, ahi_cnt = 0;
    logic        prev_E_ = 1'b1, prev_G_ = 1'b1, prev_oe = 1'b0;
    logic [15:0] prev_A = '0, prev_dq = '0;

    always #5 SIM_CLK = ~SIM_CLK;
    always @(posedge SIM_CLK) cyc <= cyc + 1;

    erasable_ram_ctrl u_dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .ram_E_(ram_E_), .ram_G_(ram_G_), .ram_W_(ram_W_), .ram_UB_(ram_UB_),
        .ram_LB_(ram_LB_), .ram_A(ram_A), .ram_dq_out(ram_dq_out),
        .ram_dq_oe(ram_dq_oe), .ram_dq_in(ram_dq_in)
    );

    ram_dq_pad u_pad (
        .ram_dq_out(ram_dq_out), .ram_dq_oe(ram_dq_oe), .ram_dq_in(ram_dq_in), .DQ(dq_bus)
    );

    erasable_ram_ctrl #(.T_SETUP(2), .T_ACCESS(6), .T_WP(3), .T_REC(2)) u_dut2 (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .req(req2), .req_we(req2_we),
        .req_addr(req2_addr), .req_wdata(req2_wdata), .req_ack(ack2),
        .rsp_valid(rv2), .rsp_rdata(rdata2), .busy(busy2),
        .ram_E_(e2_), .ram_G_(g2_), .ram_W_(w2_), .ram_UB_(ub2_),
        .ram_LB_(lb2_), .ram_A(a2), .ram_dq_out(dqo2),
        .ram_dq_oe(oe2), .ram_dq_in(dqi2)
    );

    // Behavioural SRAM: drives the bus while selected with G_ low, samples the
    // bus on the falling edge of W_.
    wire sram_drv = !ram_E_ && !ram_G_ && ram_W_;
    assign dq_bus = sram_drv ? mem[ram_A[10:0]] : 16'hzzzz;
    always @(negedge ram_W_) if (!ram_E_) mem[ram_A[10:0]] = dq_bus;

    assign dqi2 = (!e2_ && !g2_) ? mem2[a2[10:0]] : 16'h0000;
    always @(negedge w2_) if (!e2_ && oe2) mem2[a2[10:0]] = dqo2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and protocol monitor, sampled 1 ns after each falling edge.
    always @(negedge SIM_CLK) begin
        exp_t e;
        #1;
        if (SIM_RST) begin
            if (req_ack) begin
                e.we = req_we;
                if (req_we) begin
                    model[req_addr] = req_wdata;
                    e.cyc  = cyc + TS + TWP + 2;
                    e.data = '0;
                end else begin
                    e.cyc  = cyc + TS + TA + 1;
                    e.data = model[req_addr];
                end
                exp_q.push_back(e);
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_cycle", cyc, e.cyc);
                    if (!e.we) check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
                end
            end
        end
        if (!ram_G_ && !ram_W_)                          ovl_cnt++;
        if (ram_dq_oe && !ram_G_)                        oe_g_cnt++;
        if (ram_dq_oe && !prev_oe && (!prev_G_ || !ram_G_)) oe_rise_cnt++;
        if (!ram_E_ && !prev_E_ && (ram_A != prev_A || ram_dq_out != prev_dq)) stab_cnt++;
        if (sram_drv && ram_dq_oe)                       cont_cnt++;
        if (ram_UB_ != ram_E_ || ram_LB_ != ram_E_)      ub_cnt++;
        if (ram_A[15:11] != 5'd0)                        ahi_cnt++;
        prev_E_ = ram_E_; prev_G_ = ram_G_; prev_oe = ram_dq_oe;
        prev_A  = ram_A;  prev_dq = ram_dq_out;
    end

    // Call at a falling edge; returns at the falling edge after the ack cycle.
    task automatic txn(input logic we, input logic [10:0] a, input logic [15:0] d,
                       input bit hold, output int ack_cyc);
        req_we = we; req_addr = a; req_wdata = d; req = 1'b1;
        ack_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            #2;
            if (req_ack) begin
                ack_cyc = cyc;
                break;
            end
            @(negedge SIM_CLK);
        end
        check("ack_seen", 32'(ack_cyc >= 0), 32'd1);
        @(negedge SIM_CLK);
        if (!hold) req = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge SIM_CLK);
        end
        check("drain", exp_q.size(), 32'd0);
        repeat (2) @(negedge SIM_CLK);
    endtask

    task automatic txn2(input logic we, input logic [10:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rd);
        int n;
        req2_we = we; req2_addr = a; req2_wdata = d; req2 = 1'b1;
        #2;
        n = cyc;
        check("sweep_ack", 32'(ack2), 32'd1);
        @(negedge SIM_CLK);
        req2 = 1'b0;
        lat = -1;
        rd  = 'x;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (rv2) begin
                lat = cyc - n;
                rd  = rdata2;
                break;
            end
            @(negedge SIM_CLK);
        end
        repeat (4) @(negedge SIM_CLK);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          a1, a2c, a3, a4, rc, lat;
        logic [15:0] rd;
        logic        we;
        logic [10:0] ad;
        logic [15:0] dt;
        int          gap;

        for (int i = 0; i < 2048; i++) begin
            mem[i] = SRAM_INIT; mem2[i] = SRAM_INIT; model[i] = SRAM_INIT;
        end

        // Reset state
        repeat (3) @(negedge SIM_CLK);
        #1;
        check("rst_strobes", {27'd0, ram_E_, ram_G_, ram_W_, ram_UB_, ram_LB_}, 32'h1F);
        check("rst_oe_valid_busy", {29'd0, ram_dq_oe, rsp_valid, busy}, 32'd0);
        check("rst_addr", 32'(ram_A), 32'd0);
        check("rst_dq_out", 32'(ram_dq_out), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        @(negedge SIM_CLK);
        SIM_RST = 1'b1;

        // Write then read back
        txn(1'b1, 11'o0017, 16'o12345, 1'b0, a1);
        drain();
        txn(1'b0, 11'o0017, 16'h0000, 1'b0, a1);
        drain();
        check("readback_12345", 32'(rsp_rdata), 32'(16'o12345));

        // Never-written address returns SRAM power-up content
        txn(1'b0, 11'h3A5, 16'h0000, 1'b0, a1);
        drain();
        check("unwritten", 32'(rsp_rdata), 32'(SRAM_INIT));

        // Back-to-back with req held high
        txn(1'b1, 11'd0,    16'h1234, 1'b1, a1);
        txn(1'b1, 11'd2047, 16'hABCD, 1'b1, a2c);
        txn(1'b0, 11'd0,    16'h0000, 1'b1, a3);
        txn(1'b0, 11'd2047, 16'h0000, 1'b0, a4);
        drain();
        check("b2b_space_ww", a2c - a1, TS + TWP + TR + 2);
        check("b2b_space_wr", a3 - a2c, TS + TWP + TR + 2);
        check("b2b_space_rr", a4 - a3, TS + TA + TR + 1);
        check("b2b_last_rdata", 32'(rsp_rdata), 32'h0000ABCD);

        // Reset in the second W_-low cycle of a write
        txn(1'b1, 11'h055, 16'hC3C3, 1'b0, a1);
        repeat (2) @(negedge SIM_CLK);
        #3;
        check("w_low_before_rst", 32'(ram_W_), 32'd0);
        SIM_RST = 1'b0;
        exp_q.delete();
        model[11'h055] = 16'hC3C3;
        #1;
        check("midrst_strobes", {27'd0, ram_E_, ram_G_, ram_W_, ram_UB_, ram_LB_}, 32'h1F);
        check("midrst_oe_valid_busy", {29'd0, ram_dq_oe, rsp_valid, busy}, 32'd0);
        repeat (2) @(negedge SIM_CLK);
        SIM_RST = 1'b1;
        rc = cyc;
        txn(1'b0, 11'h100, 16'h0000, 1'b0, a1);
        check("ack_first_cycle", a1, rc);
        drain();

        // Random traffic with random request gaps
        for (int i = 0; i < 1000; i++) begin
            we  = 1'($urandom_range(0, 1));
            ad  = 11'($urandom_range(0, 2047));
            dt  = 16'($urandom);
            gap = $urandom_range(0, 3);
            txn(we, ad, dt, gap == 0, a1);
            if (gap > 1) repeat (gap - 1) @(negedge SIM_CLK);
        end
        req = 1'b0;
        drain();

        // Stretched timing: T_SETUP=2, T_ACCESS=6, T_WP=3, T_REC=2
        txn2(1'b1, 11'h2A0, 16'h5A5A, lat, rd);
        check("sweep_write_lat", lat, 2 + 3 + 2);
        txn2(1'b0, 11'h2A0, 16'h0000, lat, rd);
        check("sweep_read_lat", lat, 2 + 6 + 1);
        check("sweep_rdata", 32'(rd), 32'h00005A5A);
        txn2(1'b0, 11'h001, 16'h0000, lat, rd);
        check("sweep_unwritten", 32'(rd), 32'(SRAM_INIT));

        // Protocol invariants over the whole run
        check("g_w_overlap", ovl_cnt, 32'd0);
        check("oe_while_g_low", oe_g_cnt, 32'd0);
        check("oe_rise_early", oe_rise_cnt, 32'd0);
        check("addr_data_stable", stab_cnt, 32'd0);
        check("bus_contention", cont_cnt, 32'd0);
        check("byte_enables", ub_cnt, 32'd0);
        check("addr_upper_zero", ahi_cnt, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
